branch_target_predictor: RTL

//  Parametrised successor to the 1-bit branch prediction table: direct-mapped BTB plus
//  N-bit saturating-counter direction predictor. Sits in IF; looked up every cycle with
//  the current PC. Updated from ID once the branch/jump outcome is resolved.

---
 rtl/branch_target_predictor_pkg.sv | 27 ++
 rtl/branch_target_predictor_if.sv | 29 ++
 rtl/branch_target_predictor_sat_counter.sv | 23 ++
 rtl/branch_target_predictor.sv | 101 ++++++++++
 4 files changed

// File: rtl/branch_target_predictor_pkg.sv
// Shared definitions for the branch target predictor: direction-counter
// encodings as functions of the counter width, plus RISC-V control-flow opcodes.
package branch_target_predictor_pkg;

   typedef enum logic [6:0] {
      OPC_BRANCH = 7'b1100011,
      OPC_JAL    = 7'b1101111
   } opcode_e;

   // Counter encodings; w is the counter width. With w=1 weak/strong taken are both 1.
   function automatic int unsigned cnt_strong_nt(int unsigned w);
      return (w == 0) ? 0 : 0;
   endfunction

   function automatic int unsigned cnt_weak_nt(int unsigned w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

   function automatic int unsigned cnt_weak_t(int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

   function automatic int unsigned cnt_strong_t(int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Lookup (IF side) and update (ID side) signals of the branch target predictor.
interface branch_target_predictor_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned PERF_W = 32
);
   logic [DATA_W-1:0] lookup_pc;
   logic              hit;
   logic              predict_taken;
   logic [DATA_W-1:0] predict_target;
   logic              upd_valid;
   logic [DATA_W-1:0] upd_pc;
   logic [DATA_W-1:0] upd_target;
   logic              upd_taken;
   logic              upd_is_jump;
   logic              upd_mispredict;
   logic [PERF_W-1:0] mispredict_cnt;

   // Pipeline side: drives lookups and resolved outcomes.
   modport master (
      output lookup_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump, upd_mispredict,
      input  hit, predict_taken, predict_target, mispredict_cnt
   );

   // Predictor side.
   modport slave (
      input  lookup_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump, upd_mispredict,
      output hit, predict_taken, predict_target, mispredict_cnt
   );
endinterface

// File: rtl/branch_target_predictor_sat_counter.sv
// Next-state logic for one saturating direction counter.
module sat_counter #(
   parameter int unsigned CNT_W = 2
) (
   input  logic [CNT_W-1:0] cur,
   input  logic             inc,
   input  logic             force_max,
   output logic [CNT_W-1:0] nxt
);

   // Saturating increment/decrement, force_max jumps straight to all-ones.
   always_comb begin
      nxt = cur;
      if (force_max) begin
         nxt = '1;
      end else if (inc) begin
         if (cur != '1) nxt = cur + 1'b1;
      end else begin
         if (cur != '0) nxt = cur - 1'b1;
      end
   end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters and a
// saturating mispredict counter. Lookup is combinational; updates are registered.
module branch_target_predictor
   import branch_target_predictor_pkg::*;
#(
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned IDX_W   = $clog2(ENTRIES),
   parameter int unsigned TAG_W   = 8,
   parameter int unsigned CNT_W   = 2,
   parameter int unsigned PERF_W  = 32
) (
   input logic                    clk,
   input logic                    reset,
   input logic                    enable,
   branch_target_predictor_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_RESET = CNT_W'(cnt_weak_nt(CNT_W));
   localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(cnt_weak_t(CNT_W));
   localparam logic [CNT_W-1:0] CNT_JUMP  = CNT_W'(cnt_strong_t(CNT_W));

   logic              valid_q  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [DATA_W-1:0] target_q [ENTRIES];
   logic [CNT_W-1:0]  cnt_q    [ENTRIES];
   logic [PERF_W-1:0] mp_cnt_q;

   logic [IDX_W-1:0]  l_idx;
   logic [TAG_W-1:0]  l_tag;
   logic              l_hit;
   logic [IDX_W-1:0]  u_idx;
   logic [TAG_W-1:0]  u_tag;
   logic              u_hit;
   logic [CNT_W-1:0]  u_cnt_cur;
   logic [CNT_W-1:0]  u_cnt_nxt;
   logic              u_fire;
   logic              unused_pc_bits;

   assign unused_pc_bits = ^{bus.lookup_pc[DATA_W-1:IDX_W+TAG_W+2], bus.lookup_pc[1:0],
                             bus.upd_pc[DATA_W-1:IDX_W+TAG_W+2], bus.upd_pc[1:0]};

   // Zero-latency lookup against the current table contents.
   always_comb begin
      l_idx              = bus.lookup_pc[IDX_W+1:2];
      l_tag              = bus.lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
      l_hit              = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
      bus.hit            = l_hit;
      bus.predict_taken  = l_hit && cnt_q[l_idx][CNT_W-1];
      bus.predict_target = l_hit ? target_q[l_idx] : '0;
      bus.mispredict_cnt = mp_cnt_q;
   end

   // Decode of the update request.
   always_comb begin
      u_idx     = bus.upd_pc[IDX_W+1:2];
      u_tag     = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
      u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
      u_cnt_cur = cnt_q[u_idx];
      u_fire    = enable && bus.upd_valid;
   end

   sat_counter #(.CNT_W(CNT_W)) u_sat (
      .cur       (u_cnt_cur),
      .inc       (bus.upd_taken),
      .force_max (bus.upd_is_jump),
      .nxt       (u_cnt_nxt)
   );

   // Table update: train on tag match, allocate on taken miss, ignore not-taken miss.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            cnt_q[i]    <= CNT_RESET;
         end
      end else if (u_fire) begin
         if (u_hit) begin
            target_q[u_idx] <= bus.upd_target;
            cnt_q[u_idx]    <= u_cnt_nxt;
         end else if (bus.upd_taken) begin
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= bus.upd_target;
            cnt_q[u_idx]    <= bus.upd_is_jump ? CNT_JUMP : CNT_ALLOC;
         end
      end
   end

   // Saturating mispredict counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         mp_cnt_q <= '0;
      end else if (u_fire && bus.upd_mispredict && (mp_cnt_q != '1)) begin
         mp_cnt_q <= mp_cnt_q + 1'b1;
      end
   end

endmodule
